// File: rtl/arb_mux_pkg.sv
// Shared types for the packet-locking arbiter/mux.
package arb_mux_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Winner selection: first requester at or after the pointer (RR=1),
// or lowest requesting index (RR=0). Purely combinational.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int RR = 1
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_grant,
  output logic [$clog2(N)-1:0] o_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] w_base;
  logic [IW-1:0] w_cand [N];
  logic          w_found;

  assign w_base = (RR != 0) ? i_ptr : '0;

  // Search order: candidate k is the k-th channel visited from the base.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_cand
      assign w_cand[gi] = IW'((int'(w_base) + gi) % N);
    end
  endgenerate

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && i_req[w_cand[k]]) begin
        w_found           = 1'b1;
        o_grant[w_cand[k]] = 1'b1;
        o_idx             = w_cand[k];
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// N-channel packet arbiter feeding a single registered output beat.
// A channel that starts a multi-beat packet owns the output until its last beat.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int RR    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic [$clog2(N)-1:0] out_sel
);

  localparam int IW = $clog2(N);

  state_t        r_state;
  state_t        w_state_next;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] w_owner_next;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_ptr_next;

  logic          r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic          r_out_last;
  logic [IW-1:0] r_out_sel;

  logic [N-1:0]  w_owner_mask;
  logic [N-1:0]  w_req;
  logic [N-1:0]  w_grant;
  logic [IW-1:0] w_idx;
  logic          w_can_accept;
  logic          w_xfer;
  logic          w_last;

  always_comb begin
    w_owner_mask          = '0;
    w_owner_mask[r_owner] = 1'b1;
  end

  // While locked only the owner may be granted, even if it is idle.
  assign w_req = (r_state == LOCKED) ? (in_valid & w_owner_mask) : in_valid;

  rr_arbiter #(
    .N  (N),
    .RR (RR)
  ) u_arb (
    .i_req   (w_req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign w_can_accept = !r_out_valid || out_ready;
  assign in_ready     = (w_can_accept && !rst) ? w_grant : '0;
  assign w_xfer       = |in_ready;
  assign w_last       = in_last[w_idx];

  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_ptr_next   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_xfer && !w_last) begin
          w_state_next = LOCKED;
          w_owner_next = w_idx;
        end
      end
      LOCKED: begin
        if (w_xfer && w_last) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if ((RR != 0) && w_xfer && w_last) begin
      w_ptr_next = IW'((int'(w_idx) + 1) % N);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_owner <= w_owner_next;
      r_ptr   <= w_ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_sel   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data[int'(w_idx)*WIDTH +: WIDTH];
      r_out_last  <= w_last;
      r_out_sel   <= w_idx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: one round-robin and one fixed-priority instance share
// the same stimulus and are each tracked by a packet-level reference model.
module tb_arb_mux;

  logic         clk;
  logic         rst;
  logic [3:0]   in_valid;
  logic [3:0]   in_last;
  logic [127:0] in_data;
  logic         out_ready;

  logic [3:0]  ir_a, ir_b;
  logic        ov_a, ov_b, ol_a, ol_b;
  logic [31:0] od_a, od_b;
  logic [1:0]  os_a, os_b;

  int checks = 0;
  int errors = 0;

  arb_mux #(.WIDTH(32), .N(4), .RR(1)) dut_rr (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_a),
    .in_data(in_data), .in_last(in_last), .out_valid(ov_a),
    .out_ready(out_ready), .out_data(od_a), .out_last(ol_a), .out_sel(os_a)
  );

  arb_mux #(.WIDTH(32), .N(4), .RR(0)) dut_fp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir_b),
    .in_data(in_data), .in_last(in_last), .out_valid(ov_b),
    .out_ready(out_ready), .out_data(od_b), .out_last(ol_b), .out_sel(os_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, index 0 = round-robin, 1 = fixed priority.
  int          m_owner [2];
  int          m_ptr   [2];
  bit          m_rr    [2];
  logic        m_ov    [2];
  logic [31:0] m_od    [2];
  logic        m_ol    [2];
  int          m_os    [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] m_exp(int k);
    logic [3:0] g;
    int         c;
    g = 4'b0;
    if (rst || (m_ov[k] && !out_ready)) return g;
    if (m_owner[k] >= 0) begin
      if (in_valid[m_owner[k]]) g[m_owner[k]] = 1'b1;
      return g;
    end
    for (int j = 0; j < 4; j++) begin
      c = ((m_rr[k] ? m_ptr[k] : 0) + j) % 4;
      if (in_valid[c]) begin
        g[c] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic check_now();
    #1;
    chk("rr_in_ready", {28'b0, ir_a}, {28'b0, m_exp(0)});
    chk("rr_out_valid", {31'b0, ov_a}, {31'b0, m_ov[0]});
    chk("rr_out_data", od_a, m_od[0]);
    chk("rr_out_last", {31'b0, ol_a}, {31'b0, m_ol[0]});
    chk("rr_out_sel", {30'b0, os_a}, m_os[0]);
    chk("fp_in_ready", {28'b0, ir_b}, {28'b0, m_exp(1)});
    chk("fp_out_valid", {31'b0, ov_b}, {31'b0, m_ov[1]});
    chk("fp_out_data", od_b, m_od[1]);
    chk("fp_out_last", {31'b0, ol_b}, {31'b0, m_ol[1]});
    chk("fp_out_sel", {30'b0, os_b}, m_os[1]);
  endtask

  task automatic tick();
    logic [3:0] g [2];
    int         idx;
    for (int k = 0; k < 2; k++) g[k] = m_exp(k);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_owner[k] = -1; m_ptr[k] = 0; m_ov[k] = 1'b0;
        m_od[k] = 32'h0; m_ol[k] = 1'b0; m_os[k] = 0;
      end else if (g[k] != 4'b0) begin
        idx = 0;
        for (int j = 0; j < 4; j++) if (g[k][j]) idx = j;
        m_ov[k] = 1'b1;
        m_od[k] = in_data[idx*32 +: 32];
        m_ol[k] = in_last[idx];
        m_os[k] = idx;
        if (in_last[idx]) begin
          m_owner[k] = -1;
          if (m_rr[k]) m_ptr[k] = (idx + 1) % 4;
        end else begin
          m_owner[k] = idx;
        end
      end else if (out_ready) begin
        m_ov[k] = 1'b0;
      end
    end
    #1;
  endtask

  task automatic set_data(input int ch, input logic [31:0] v);
    in_data[ch*32 +: 32] = v;
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  exp_ir;
    logic        exp_ov;
    logic [1:0]  exp_sel;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl [9];

  initial begin
    m_rr[0] = 1'b1;
    m_rr[1] = 1'b0;
    rst = 1'b1; in_valid = 4'hF; in_last = 4'hF; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_data(i, 32'hA0 + i);
    tick();

    // Reset hold, then round-robin single-beat packets from all channels.
    tbl[0] = '{1'b1, 4'hF, 4'b0000, 1'b0, 2'd0, 32'h0};
    tbl[1] = '{1'b1, 4'hF, 4'b0000, 1'b0, 2'd0, 32'h0};
    tbl[2] = '{1'b0, 4'hF, 4'b0001, 1'b0, 2'd0, 32'h0};
    tbl[3] = '{1'b0, 4'hF, 4'b0010, 1'b1, 2'd0, 32'hA0};
    tbl[4] = '{1'b0, 4'hF, 4'b0100, 1'b1, 2'd1, 32'hA1};
    tbl[5] = '{1'b0, 4'hF, 4'b1000, 1'b1, 2'd2, 32'hA2};
    tbl[6] = '{1'b0, 4'hF, 4'b0001, 1'b1, 2'd3, 32'hA3};
    tbl[7] = '{1'b0, 4'h0, 4'b0000, 1'b1, 2'd0, 32'hA0};
    tbl[8] = '{1'b0, 4'h0, 4'b0000, 1'b0, 2'd0, 32'hA0};
    for (int i = 0; i < 9; i++) begin
      rst = tbl[i].rst; in_valid = tbl[i].valid;
      check_now();
      chk($sformatf("tbl%0d_in_ready", i), {28'b0, ir_a}, {28'b0, tbl[i].exp_ir});
      chk($sformatf("tbl%0d_out_valid", i), {31'b0, ov_a}, {31'b0, tbl[i].exp_ov});
      chk($sformatf("tbl%0d_out_sel", i), {30'b0, os_a}, {30'b0, tbl[i].exp_sel});
      chk($sformatf("tbl%0d_out_data", i), od_a, tbl[i].exp_data);
      tick();
    end

    // Locking: ch1 three-beat packet with a gap, ch2 waiting.
    set_data(1, 32'h11); set_data(2, 32'h22);
    in_valid = 4'b0110; in_last = 4'b0100;
    check_now(); chk("lock_c1_ir", {28'b0, ir_a}, 32'b0010); tick();
    set_data(1, 32'h12);
    check_now(); chk("lock_c2_ir", {28'b0, ir_a}, 32'b0010);
    chk("lock_c2_data", od_a, 32'h11); tick();
    in_valid = 4'b0100;
    check_now(); chk("lock_gap_ir", {28'b0, ir_a}, 32'b0000);
    chk("lock_gap_data", od_a, 32'h12); tick();
    set_data(1, 32'h13); in_valid = 4'b0110; in_last = 4'b0110;
    check_now(); chk("lock_c4_ir", {28'b0, ir_a}, 32'b0010); tick();
    in_valid = 4'b0100;
    check_now(); chk("lock_c5_ir", {28'b0, ir_a}, 32'b0100);
    chk("lock_c5_data", od_a, 32'h13); tick();
    in_valid = 4'b0000;
    check_now(); chk("lock_c6_data", od_a, 32'h22); tick();

    // Backpressure on a held beat.
    set_data(3, 32'hDEADBEEF); in_valid = 4'b1000; in_last = 4'b1000;
    check_now(); chk("bp_first_ir", {28'b0, ir_a}, 32'b1000); tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_now();
      chk($sformatf("bp%0d_ir", i), {28'b0, ir_a}, 32'b0000);
      chk($sformatf("bp%0d_data", i), od_a, 32'hDEADBEEF);
      chk($sformatf("bp%0d_sel", i), {30'b0, os_a}, 32'd3);
      chk($sformatf("bp%0d_ov", i), {31'b0, ov_a}, 32'd1);
      tick();
    end
    out_ready = 1'b1;
    check_now(); chk("bp_resume_ir", {28'b0, ir_a}, 32'b1000); tick();
    in_valid = 4'b0000;
    check_now(); tick();

    // Reset in the middle of a ch2 packet while ch0 waits.
    set_data(2, 32'h20000001); set_data(0, 32'h00000C00);
    in_valid = 4'b0100; in_last = 4'b0000;
    check_now(); chk("rstmid_b1_ir", {28'b0, ir_a}, 32'b0100); tick();
    set_data(2, 32'h20000002); in_valid = 4'b0101;
    check_now(); chk("rstmid_b2_ir", {28'b0, ir_a}, 32'b0100); tick();
    rst = 1'b1;
    check_now(); chk("rstmid_rst_ir", {28'b0, ir_a}, 32'b0000); tick();
    rst = 1'b0;
    check_now(); chk("rstmid_after_ov", {31'b0, ov_a}, 32'd0);
    chk("rstmid_after_ir", {28'b0, ir_a}, 32'b0001); tick();
    in_valid = 4'b0000;
    check_now(); chk("rstmid_sel", {30'b0, os_a}, 32'd0); tick();

    // Fixed priority: ch0 and ch3 always valid, ch0 must always win.
    rst = 1'b1; check_now(); tick();
    rst = 1'b0; in_valid = 4'b1001; in_last = 4'b1001;
    for (int i = 0; i < 6; i++) begin
      check_now();
      chk($sformatf("fp%0d_ir", i), {28'b0, ir_b}, 32'b0001);
      if (i > 0) chk($sformatf("fp%0d_sel", i), {30'b0, os_b}, 32'd0);
      tick();
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      in_valid  = 4'($urandom);
      in_last   = 4'($urandom) | 4'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      check_now();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
